// File: rtl/cacheline_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cacheline_adapter
//  Description : Turns the data cache's single-transfer 256-bit line port
//                (dfp_*) into 4-beat 64-bit bursts on the banked memory port
//                (bmem_*). One line read or one line write is handled at a
//                time, and a one-cycle dfp_resp marks completion.
//                Optional protocol checker: define CACHELINE_ADAPTER_CHECK_EN
//                to drive the sticky err output. Without it, err is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    // Beats per line. The ratio must be a power of two so that the counter
    // wraps naturally back to 0 at the end of a burst.
    localparam int BURST_LEN = LINE_W / BEAT_W;
    localparam int CNT_W     = $clog2(BURST_LEN);
    // Byte-offset bits inside a line; these are forced to 0 in the address.
    localparam int OFF_W     = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [31:0]         addr_q;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_asm_d;
    logic [LINE_W-1:0]   dfp_rdata_q;
    logic                dfp_resp_q;
    logic                bmem_read_q;
    logic                bmem_write_q;
    logic [BEAT_W-1:0]   bmem_wdata_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Line buffer with the incoming read beat merged into its slot.
    always_comb begin
        line_asm_d = line_q;
        line_asm_d[BEAT_W*cnt_q +: BEAT_W] = bmem_rdata;
    end

    // Transfer FSM; every output is a register loaded for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            dfp_rdata_q  <= '0;
            dfp_resp_q   <= 1'b0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write wins over read so a dirty victim leaves first.
                    if (dfp_write) begin
                        addr_q       <= {dfp_addr[31:OFF_W], OFF_W'(0)};
                        line_q       <= dfp_wdata;
                        bmem_wdata_q <= dfp_wdata[BEAT_W-1:0];
                        bmem_write_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= WR_BURST;
                    end else if (dfp_read) begin
                        addr_q      <= {dfp_addr[31:OFF_W], OFF_W'(0)};
                        bmem_read_q <= 1'b1;
                        state_q     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bmem_rvalid) begin
                        line_q <= line_asm_d;
                        cnt_q  <= cnt_d;
                        if (cnt_q == c_LAST_BEAT) begin
                            dfp_rdata_q <= line_asm_d;
                            dfp_resp_q  <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    // Only the first beat waits for ready; the rest stream.
                    if (bmem_ready || (cnt_q != '0)) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == c_LAST_BEAT) begin
                            bmem_write_q <= 1'b0;
                            dfp_resp_q   <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            bmem_wdata_q <= line_q[BEAT_W*cnt_d +: BEAT_W];
                        end
                    end
                end
                DONE: begin
                    // Requests are still high here; they are not resampled
                    // until the FSM is back in IDLE.
                    dfp_resp_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dfp_rdata  = dfp_rdata_q;
    assign dfp_resp   = dfp_resp_q;
    assign bmem_addr  = addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;

`ifdef CACHELINE_ADAPTER_CHECK_EN
    logic err_q;
    logic w_chk_both;
    logic w_chk_align;
    logic w_chk_stray;
    logic w_chk_raddr;

    assign w_chk_both  = (state_q == IDLE) && dfp_read && dfp_write;
    assign w_chk_align = (state_q == IDLE) && (dfp_read || dfp_write) &&
                         (dfp_addr[OFF_W-1:0] != '0);
    assign w_chk_stray = bmem_rvalid && (state_q != RD_WAIT);
    assign w_chk_raddr = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr != addr_q);

    // Sticky protocol-violation flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_chk_both || w_chk_align || w_chk_stray || w_chk_raddr) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Inputs that only the checker looks at.
    logic w_unused;
    assign w_unused = ^{bmem_raddr, dfp_addr[OFF_W-1:0]};
    assign err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adapter
//  Description : Self-checking bench for cacheline_adapter: a table of line
//                transactions with hand-computed latencies, plus directed
//                sequences for writeback-then-fill, reset mid-burst and a
//                read-address mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         err;

`ifdef CACHELINE_ADAPTER_CHECK_EN
    localparam logic c_EXP_CHK = 1'b1;
`else
    localparam logic c_EXP_CHK = 1'b0;
`endif

    cacheline_adapter #(.LINE_W(256), .BEAT_W(64)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
        int           dly;       // cycles bmem_ready is held low at the start
        int           gap;       // idle cycles between read beats
        int           exp_resp;  // cycle of dfp_resp, request cycle = 0
    } vec_t;

    vec_t         vecs [6];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] last_rd = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int dly, input int exp_resp);
        int cyc;
        int nwr;
        int beat;
        bit done;
        @(negedge clk);
        dfp_read    = 1'b0;
        dfp_write   = 1'b1;
        dfp_addr    = addr;
        dfp_wdata   = line;
        bmem_ready  = (dly == 0);
        bmem_rvalid = 1'b0;
        cyc = 0; nwr = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bmem_ready = (cyc > dly);
            if (dfp_resp) begin
                check("wr_resp_cycle", 256'(cyc), 256'(exp_resp));
                check("wr_beat_cycles", 256'(nwr), 256'(dly + 4));
                check("wr_rdata_hold", dfp_rdata, last_rd);
                done = 1'b1;
            end else if (bmem_write) begin
                nwr++;
                beat = (cyc <= dly) ? 0 : cyc - dly - 1;
                if (beat > 3) beat = 3;
                check("wr_addr", 256'(bmem_addr), 256'(addr));
                check("wr_data", 256'(bmem_wdata), 256'(line[64*beat +: 64]));
            end
        end
        if (!done) check("wr_timeout", 256'(0), 256'(1));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input int dly, input int gap, input int exp_resp,
                           input int bad_beat);
        int cyc;
        int acc;
        int k;
        int ncmd;
        bit done;
        @(negedge clk);
        dfp_write   = 1'b0;
        dfp_read    = 1'b1;
        dfp_addr    = addr;
        bmem_ready  = (dly == 0);
        bmem_rvalid = 1'b0;
        cyc = 0; acc = 0; k = 0; ncmd = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bmem_ready = (cyc > dly);
            check("rd_no_write", 256'(bmem_write), 256'(0));
            if (dfp_resp) begin
                bmem_rvalid = 1'b0;
                check("rd_resp_cycle", 256'(cyc), 256'(exp_resp));
                check("rd_cmd_cycles", 256'(ncmd), 256'(dly + 1));
                check("rd_line", dfp_rdata, line);
                last_rd = line;
                done = 1'b1;
            end else begin
                if (bmem_read) begin
                    ncmd++;
                    check("rd_addr", 256'(bmem_addr), 256'(addr));
                    if (bmem_ready && acc == 0) acc = cyc;
                end
                if (acc != 0 && cyc > acc && k < 4 && ((cyc - acc - 1) % (gap + 1)) == 0) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = line[64*k +: 64];
                    bmem_raddr  = (k == bad_beat) ? (addr ^ 32'h0000_0100) : addr;
                    k++;
                end else begin
                    bmem_rvalid = 1'b0;
                    bmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                    bmem_raddr  = 32'h0;
                end
            end
        end
        if (!done) check("rd_timeout", 256'(0), 256'(1));
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        bmem_rvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("idle_resp", 256'(dfp_resp), 256'(0));
            check("idle_write", 256'(bmem_write), 256'(0));
            check("idle_read", 256'(bmem_read), 256'(0));
            @(negedge clk);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_resp"},   256'(dfp_resp),   256'(0));
        check({tag, "_bread"},  256'(bmem_read),  256'(0));
        check({tag, "_bwrite"}, 256'(bmem_write), 256'(0));
        check({tag, "_baddr"},  256'(bmem_addr),  256'(0));
        check({tag, "_bwdata"}, 256'(bmem_wdata), 256'(0));
        check({tag, "_rdata"},  dfp_rdata,        256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_1240,
                    {64'hDDDD_DDDD_DDDD_0003, 64'hCCCC_CCCC_CCCC_0002,
                     64'hBBBB_BBBB_BBBB_0001, 64'hAAAA_AAAA_AAAA_0000}, 0, 0, 5};
        vecs[1] = '{1'b1, 32'h0000_2000,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h5555_AAAA_5555_AAAA, 64'h1111_2222_3333_4444}, 3, 0, 8};
        vecs[2] = '{1'b0, 32'h8000_0020,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 2, 12};
        vecs[3] = '{1'b0, 32'h0001_0040,
                    {64'hA0A1_A2A3_A4A5_A6A7, 64'hB0B1_B2B3_B4B5_B6B7,
                     64'hC0C1_C2C3_C4C5_C6C7, 64'hD0D1_D2D3_D4D5_D6D7}, 0, 0, 6};
        vecs[4] = '{1'b1, 32'h0000_0100,
                    {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                     64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001}, 1, 0, 6};
        vecs[5] = '{1'b0, 32'hFFFF_FFE0,
                    {64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
                     64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE}, 2, 1, 11};

        rst         = 1'b1;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");
        check("reset_err", 256'(err), 256'(0));

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].line, vecs[i].dly, vecs[i].exp_resp);
            else
                do_read(vecs[i].addr, vecs[i].line, vecs[i].dly, vecs[i].gap,
                        vecs[i].exp_resp, -1);
            check("vec_err", 256'(err), 256'(0));
            idle_cycles(2);
        end

        // Writeback then fill: write held through DONE, read right after.
        do_write(32'h0000_5000, vecs[1].line, 0, 5);
        do_read(32'h0000_6000, vecs[3].line, 0, 0, 6, -1);
        idle_cycles(2);

        // Reset after two read beats, then two stray beats.
        @(negedge clk);
        dfp_addr   = 32'h0000_4000;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        @(negedge clk);
        check("abort_bread", 256'(bmem_read), 256'(1));
        @(negedge clk);
        bmem_rvalid = 1'b1; bmem_rdata = 64'h0101_0101_0101_0101; bmem_raddr = 32'h0000_4000;
        @(negedge clk);
        bmem_rdata = 64'h0202_0202_0202_0202;
        @(negedge clk);
        bmem_rvalid = 1'b0; dfp_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        check_zero_outputs("abort");
        check("abort_err", 256'(err), 256'(0));
        bmem_rvalid = 1'b1; bmem_rdata = 64'h0303_0303_0303_0303;
        @(negedge clk);
        check("stray_resp1", 256'(dfp_resp), 256'(0));
        bmem_rdata = 64'h0404_0404_0404_0404;
        @(negedge clk);
        bmem_rvalid = 1'b0;
        check("stray_resp2", 256'(dfp_resp), 256'(0));
        check("stray_rdata", dfp_rdata, 256'(0));
        check("stray_err", 256'(err), 256'(c_EXP_CHK));
        reset_pulse();
        check("clear_err", 256'(err), 256'(0));

        // Wrong bmem_raddr on beat 1: data still assembled, err sticky.
        do_read(32'h0000_3000, vecs[2].line, 0, 0, 6, 1);
        check("raddr_err", 256'(err), 256'(c_EXP_CHK));
        idle_cycles(3);
        check("raddr_err_sticky", 256'(err), 256'(c_EXP_CHK));
        reset_pulse();
        check("raddr_err_clear", 256'(err), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Downstream neighbour of the 4-way data cache. Converts the cache's 256-bit single-transfer line port (dfp_*) into 4-beat, 64-bit bursts on the banked memory port (bmem_*). Handles one line read or one line write at a time and returns a one-cycle dfp_resp on completion.

Parameters:
LINE_W, 256, cache line width in bits
BEAT_W, 64, burst beat width in bits; BURST_LEN = LINE_W/BEAT_W = 4 (derived localparam, must be a power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dfp_addr  in  32  line address from cache; bits [4:0] are 0
dfp_read  in  1  line read request, held until dfp_resp
dfp_write  in  1  line write request, held until dfp_resp
dfp_wdata  in  LINE_W  line to write; valid while dfp_write is high
dfp_rdata  out  LINE_W  assembled read line; valid while dfp_resp is high
dfp_resp  out  1  one-cycle completion pulse
bmem_addr  out  32  burst base address
bmem_read  out  1  burst read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_W  write beat data
bmem_ready  in  1  memory can accept a command
bmem_raddr  in  32  base address of the returning read burst
bmem_rdata  in  BEAT_W  read beat data
bmem_rvalid  in  1  read beat valid
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (synchronous): state=IDLE, beat counter=0. Outputs: dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0, err=0. A reset mid-burst abandons the burst. Any beats still returning afterwards are ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE.
- IDLE:
  - On dfp_write=1: latch {dfp_addr[31:5],5'b0} and dfp_wdata into the line buffer, then go to WR_BURST.
  - Else on dfp_read=1: latch the address, then go to RD_REQ.
  - Write wins if both are high.
- RD_REQ:
  - bmem_read=1 and bmem_addr=latched address.
  - The command is accepted in a cycle with bmem_ready=1; then go to RD_WAIT with counter=0.
  - If bmem_ready=0, hold bmem_read high.
- RD_WAIT:
  - Each cycle with bmem_rvalid=1: store bmem_rdata into line[BEAT_W*cnt +: BEAT_W], then cnt++.
  - Gaps between beats are allowed.
  - After beat BURST_LEN-1 is stored, go to DONE.
- WR_BURST:
  - bmem_write=1, bmem_addr=latched address, bmem_wdata=line[BEAT_W*cnt +: BEAT_W].
  - Beat 0 is issued only in a cycle with bmem_ready=1; while bmem_ready=0, hold beat 0 on the bus.
  - Beats 1..3 follow on consecutive cycles regardless of bmem_ready.
  - After beat 3, go to DONE.
- DONE:
  - dfp_resp=1 for exactly one cycle, then return to IDLE.
  - For reads, dfp_rdata = assembled line.
- dfp_rdata holds its last value outside DONE.
- dfp_read and dfp_write are still high during the DONE cycle and must not start a new transfer. A request is sampled only in IDLE, so a back-to-back writeback-then-fill starts one cycle after dfp_resp.
- Latency with an always-ready memory:
  - Write: latch at T0, beats at T1..T4, dfp_resp at T5.
  - Read: latch at T0, bmem_read at T1, dfp_resp the cycle after the 4th rvalid.
- Counter is log2(BURST_LEN) bits wide and wraps to 0 at end of burst.
- bmem_rvalid outside RD_WAIT is ignored.

Optional Feature:
Macro CACHELINE_ADAPTER_CHECK_EN.
- Defined: err becomes sticky-set (cleared only by rst) on any of:
  - dfp_read and dfp_write both high in IDLE;
  - dfp_addr[4:0]!=0 at request sample;
  - bmem_rvalid=1 while not in RD_WAIT;
  - bmem_raddr != latched address on any beat in RD_WAIT.
- Undefined: err is tied to 0 and no checking logic is synthesized.
- Functional behaviour is identical either way.

Test Plan:
- Write, always-ready: dfp_write with addr 0x0000_1240 and line beats {D,C,B,A}. Required: bmem_addr=0x0000_1240, bmem_wdata A,B,C,D on T1..T4, dfp_resp only at T5.
- Write, ready low 3 cycles: bmem_write held with beat 0 for 3 cycles. Required: beats 0..3 issued back-to-back once ready rises, then dfp_resp.
- Read with gaps: dfp_read at 0x8000_0020; rvalid beats 0x11..,0x22..,0x33..,0x44.. with 2-cycle gaps. Required: one bmem_read cycle; dfp_rdata={44,33,22,11} with dfp_resp one cycle after the last beat.
- Writeback then fill: dfp_write held until resp, then dfp_read asserted next cycle. Required: no second write burst; read issues 1 cycle after resp.
- Reset during RD_WAIT after 2 beats, then 2 stray rvalids. Required: all outputs 0, no dfp_resp; with CHECK_EN, err=1.
- With CHECK_EN: bmem_raddr mismatch on beat 1. Required: err=1 and stays 1 until rst; data path unaffected.
